// File: rtl/rv32i_types.sv
`default_nettype none
// ============================================================================
// rv32i_types : shared I-cache miss-handler types (MSHR entry state and record)
// Revision    : 1.0
// ============================================================================
package rv32i_types;

  // Tag storage is sized for the widest supported line tag; users widen on write.
  localparam int c_TAG_MAX_W = 64;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    PENDING = 2'd1,
    ISSUED  = 2'd2,
    ORPHAN  = 2'd3
  } mshr_state_t;

  typedef struct packed {
    mshr_state_t            state;
    logic [c_TAG_MAX_W-1:0] tag;
  } mshr_entry_t;

endpackage
`default_nettype wire

// File: rtl/mshr_prio_enc.sv
`default_nettype none
// ============================================================================
// mshr_prio_enc : lowest-index-first priority encoder over a request vector
// Revision      : 1.0
// ============================================================================
module mshr_prio_enc #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  always_comb begin
    o_idx   = '0;
    o_valid = |i_req;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) o_idx = IDX_W'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/icache_mshr_fill_unit.sv
`default_nettype none
// ============================================================================
// icache_mshr_fill_unit : multi-entry I-cache miss handler with merge, DFP
//                         issue, response matching and flush orphaning.
// Optional next-line prefetch: define ICACHE_NEXT_LINE_PREFETCH_EN.
// Revision              : 1.0
// ============================================================================
module icache_mshr_fill_unit
  import rv32i_types::*;
#(
  parameter int NUM_MSHR = 4,
  parameter int ADDR_W   = 32,
  parameter int LINE_W   = 256,
  parameter int OFFSET_W = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          miss_valid,
  input  logic [ADDR_W-1:0]             miss_addr,
  output logic                          miss_ready,
  input  logic                          flush,
  output logic [ADDR_W-1:0]             dfp_addr,
  output logic                          dfp_read,
  input  logic [LINE_W-1:0]             dfp_rdata,
  input  logic [ADDR_W-1:0]             dfp_raddr,
  input  logic                          dfp_resp,
  output logic                          fill_valid,
  output logic [ADDR_W-1:0]             fill_addr,
  output logic [LINE_W-1:0]             fill_data,
  output logic [$clog2(NUM_MSHR+1)-1:0] outstanding,
  output logic                          unmatched_resp
);

  localparam int c_TAG_W = ADDR_W - OFFSET_W;
  localparam int c_IDX_W = (NUM_MSHR > 1) ? $clog2(NUM_MSHR) : 1;
  localparam int c_CNT_W = $clog2(NUM_MSHR + 1);

  mshr_entry_t r_entry [NUM_MSHR];

  logic [c_TAG_W-1:0]  w_miss_tag;
  logic [c_TAG_W-1:0]  w_resp_tag;
  logic [NUM_MSHR-1:0] w_free;
  logic [NUM_MSHR-1:0] w_pending;
  logic [NUM_MSHR-1:0] w_active_hit;
  logic [NUM_MSHR-1:0] w_issued_hit;
  logic [NUM_MSHR-1:0] w_orphan_hit;
  logic [c_IDX_W-1:0]  w_free_idx, w_pend_idx, w_iss_idx, w_orph_idx;
  logic                w_free_any, w_pend_any, w_iss_any, w_orph_any;
  logic [c_CNT_W-1:0]  w_count;

  assign w_miss_tag = miss_addr[ADDR_W-1:OFFSET_W];
  assign w_resp_tag = dfp_raddr[ADDR_W-1:OFFSET_W];

  logic w_unused_ok;
  assign w_unused_ok = ^{miss_addr[OFFSET_W-1:0], dfp_raddr[OFFSET_W-1:0]};

  always_comb begin
    w_count = '0;
    for (int i = 0; i < NUM_MSHR; i++) begin
      w_free[i]       = (r_entry[i].state == FREE);
      w_pending[i]    = (r_entry[i].state == PENDING);
      w_active_hit[i] = ((r_entry[i].state == PENDING) || (r_entry[i].state == ISSUED)) &&
                        (r_entry[i].tag == c_TAG_MAX_W'(w_miss_tag));
      w_issued_hit[i] = dfp_resp && (r_entry[i].state == ISSUED) &&
                        (r_entry[i].tag == c_TAG_MAX_W'(w_resp_tag));
      w_orphan_hit[i] = dfp_resp && (r_entry[i].state == ORPHAN) &&
                        (r_entry[i].tag == c_TAG_MAX_W'(w_resp_tag));
      if (!w_free[i]) w_count = w_count + c_CNT_W'(1);
    end
  end

  assign outstanding = w_count;

  mshr_prio_enc #(.N(NUM_MSHR), .IDX_W(c_IDX_W)) u_free_enc (
    .i_req(w_free), .o_idx(w_free_idx), .o_valid(w_free_any));
  mshr_prio_enc #(.N(NUM_MSHR), .IDX_W(c_IDX_W)) u_issue_enc (
    .i_req(w_pending), .o_idx(w_pend_idx), .o_valid(w_pend_any));
  mshr_prio_enc #(.N(NUM_MSHR), .IDX_W(c_IDX_W)) u_iss_hit_enc (
    .i_req(w_issued_hit), .o_idx(w_iss_idx), .o_valid(w_iss_any));
  mshr_prio_enc #(.N(NUM_MSHR), .IDX_W(c_IDX_W)) u_orph_hit_enc (
    .i_req(w_orphan_hit), .o_idx(w_orph_idx), .o_valid(w_orph_any));

  logic w_merge, w_alloc, w_issue_any;
  logic [c_IDX_W-1:0] w_issue_idx;
  logic [c_TAG_W-1:0] w_issue_tag;
  logic w_resp_orphan, w_resp_issued;

  assign w_merge    = |w_active_hit;
  assign miss_ready = miss_valid && !flush && (w_merge || w_free_any);
  assign w_alloc    = miss_valid && !flush && !w_merge && w_free_any;

  // With nothing queued, a fresh allocation is sent straight away (1-cycle latency).
  assign w_issue_any = !flush && (w_pend_any || w_alloc);
  assign w_issue_idx = w_pend_any ? w_pend_idx : w_free_idx;
  assign w_issue_tag = w_pend_any ? r_entry[w_pend_idx].tag[c_TAG_W-1:0] : w_miss_tag;

  // An orphaned read of the same line was sent earlier, so it claims the response first.
  assign w_resp_orphan = dfp_resp && w_orph_any;
  assign w_resp_issued = dfp_resp && !w_orph_any && w_iss_any;

  logic               w_pf_alloc;
  logic [c_IDX_W-1:0] w_pf_idx;
  logic [c_TAG_W-1:0] w_pf_tag;

`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
  logic [NUM_MSHR-1:0] w_pf_free;
  logic [NUM_MSHR-1:0] w_pf_present;
  logic                w_pf_any;

  assign w_pf_tag  = w_miss_tag + c_TAG_W'(1);
  assign w_pf_free = w_free & ~(NUM_MSHR'(1) << w_free_idx);

  always_comb begin
    for (int i = 0; i < NUM_MSHR; i++) begin
      w_pf_present[i] = ((r_entry[i].state == PENDING) || (r_entry[i].state == ISSUED)) &&
                        (r_entry[i].tag == c_TAG_MAX_W'(w_pf_tag));
    end
  end

  mshr_prio_enc #(.N(NUM_MSHR), .IDX_W(c_IDX_W)) u_pf_enc (
    .i_req(w_pf_free), .o_idx(w_pf_idx), .o_valid(w_pf_any));

  assign w_pf_alloc = w_alloc && !(|w_pf_present) && w_pf_any;
`else
  assign w_pf_alloc = 1'b0;
  assign w_pf_idx   = '0;
  assign w_pf_tag   = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_MSHR; i++) begin
        r_entry[i].state <= FREE;
        r_entry[i].tag   <= '0;
      end
      dfp_read       <= 1'b0;
      dfp_addr       <= '0;
      fill_valid     <= 1'b0;
      fill_addr      <= '0;
      fill_data      <= '0;
      unmatched_resp <= 1'b0;
    end else begin
      dfp_read <= w_issue_any;
      if (w_issue_any) dfp_addr <= {w_issue_tag, {OFFSET_W{1'b0}}};

      fill_valid <= w_resp_issued && !flush;
      if (w_resp_issued && !flush) begin
        fill_addr <= {w_resp_tag, {OFFSET_W{1'b0}}};
        fill_data <= dfp_rdata;
      end

      unmatched_resp <= dfp_resp && !w_orph_any && !w_iss_any;

      for (int i = 0; i < NUM_MSHR; i++) begin
        if ((w_resp_orphan && (w_orph_idx == c_IDX_W'(i))) ||
            (w_resp_issued && (w_iss_idx == c_IDX_W'(i)))) begin
          r_entry[i].state <= FREE;
        end else if (flush) begin
          if (r_entry[i].state == PENDING) r_entry[i].state <= FREE;
          else if (r_entry[i].state == ISSUED) r_entry[i].state <= ORPHAN;
        end else if (w_issue_any && (w_issue_idx == c_IDX_W'(i))) begin
          r_entry[i].state <= ISSUED;
          if (!w_pend_any) r_entry[i].tag <= c_TAG_MAX_W'(w_miss_tag);
        end else if (w_alloc && (w_free_idx == c_IDX_W'(i))) begin
          r_entry[i].state <= PENDING;
          r_entry[i].tag   <= c_TAG_MAX_W'(w_miss_tag);
        end else if (w_pf_alloc && (w_pf_idx == c_IDX_W'(i))) begin
          r_entry[i].state <= PENDING;
          r_entry[i].tag   <= c_TAG_MAX_W'(w_pf_tag);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_icache_mshr_fill_unit.sv
`default_nettype none
// ============================================================================
// tb_icache_mshr_fill_unit : directed bench for icache_mshr_fill_unit
// Revision                 : 1.0
// ============================================================================
module tb_icache_mshr_fill_unit;

  localparam int NUM_MSHR = 4;
  localparam int ADDR_W   = 32;
  localparam int LINE_W   = 256;
  localparam int OFFSET_W = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              miss_valid = 1'b0;
  logic [ADDR_W-1:0] miss_addr = '0;
  logic              flush = 1'b0;
  logic [LINE_W-1:0] dfp_rdata = '0;
  logic [ADDR_W-1:0] dfp_raddr = '0;
  logic              dfp_resp = 1'b0;

  logic              miss_ready;
  logic [ADDR_W-1:0] dfp_addr;
  logic              dfp_read;
  logic              fill_valid;
  logic [ADDR_W-1:0] fill_addr;
  logic [LINE_W-1:0] fill_data;
  logic [2:0]        outstanding;
  logic              unmatched_resp;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  icache_mshr_fill_unit #(
    .NUM_MSHR(NUM_MSHR), .ADDR_W(ADDR_W), .LINE_W(LINE_W), .OFFSET_W(OFFSET_W)
  ) dut (
    .clk(clk), .rst(rst),
    .miss_valid(miss_valid), .miss_addr(miss_addr), .miss_ready(miss_ready),
    .flush(flush),
    .dfp_addr(dfp_addr), .dfp_read(dfp_read),
    .dfp_rdata(dfp_rdata), .dfp_raddr(dfp_raddr), .dfp_resp(dfp_resp),
    .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_data(fill_data),
    .outstanding(outstanding), .unmatched_resp(unmatched_resp)
  );

  function automatic logic [LINE_W-1:0] line_of(input logic [ADDR_W-1:0] a);
    return {8{a ^ 32'hA5A5_0000}};
  endfunction

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic give_resp(input logic [ADDR_W-1:0] a);
    dfp_resp  = 1'b1;
    dfp_raddr = a;
    dfp_rdata = line_of(a);
  endtask

  task automatic give_miss(input logic [ADDR_W-1:0] a);
    miss_valid = 1'b1;
    miss_addr  = a;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [ADDR_W-1:0] addrs [4];
    addrs[0] = 32'h100; addrs[1] = 32'h200; addrs[2] = 32'h300; addrs[3] = 32'h400;

    // reset state
    tick();
    tick();
    chk("rst_dfp_read", dfp_read, 0);
    chk("rst_dfp_addr", dfp_addr, 0);
    chk("rst_fill_valid", fill_valid, 0);
    chk("rst_fill_addr", fill_addr, 0);
    chk("rst_fill_data", fill_data, 0);
    chk("rst_unmatched", unmatched_resp, 0);
    chk("rst_outstanding", outstanding, 0);
    rst = 1'b1;

    // single miss, offset bits ignored
    give_miss(32'h0000_1004);
    chk("t1_ready", miss_ready, 1);
    tick();
    miss_valid = 1'b0;
    chk("t1_read", dfp_read, 1);
    chk("t1_addr", dfp_addr, 32'h0000_1000);
    chk("t1_outst", outstanding, 1);
    tick();
    chk("t1_read_pulse", dfp_read, 0);
    give_resp(32'h0000_1000);
    tick();
    dfp_resp = 1'b0;
    chk("t1_fill_valid", fill_valid, 1);
    chk("t1_fill_addr", fill_addr, 32'h0000_1000);
    chk("t1_fill_data", fill_data, line_of(32'h0000_1000));
    chk("t1_outst_done", outstanding, 0);
    tick();
    chk("t1_fill_pulse", fill_valid, 0);

    // fill all four entries, fifth miss stalls
    for (int i = 0; i < 4; i++) begin
      give_miss(addrs[i]);
      chk("t2_ready", miss_ready, 1);
      tick();
      chk("t2_read", dfp_read, 1);
      chk("t2_addr", dfp_addr, addrs[i]);
    end
    chk("t2_outst_full", outstanding, 4);
    give_miss(32'h500);
    chk("t2_full_ready", miss_ready, 0);
    tick();
    chk("t2_no_read", dfp_read, 0);
    give_resp(32'h100);
    #1;
    chk("t2_freed_not_same_cycle", miss_ready, 0);
    tick();
    dfp_resp = 1'b0;
    chk("t2_fill_100", fill_valid, 1);
    chk("t2_fill_addr_100", fill_addr, 32'h100);
    chk("t2_outst_3", outstanding, 3);
    #1;
    chk("t2_ready_after_free", miss_ready, 1);
    tick();
    miss_valid = 1'b0;
    chk("t2_read_500", dfp_read, 1);
    chk("t2_addr_500", dfp_addr, 32'h500);
    for (int i = 1; i < 4; i++) begin
      give_resp(addrs[i]);
      tick();
      chk("t2_fill_v", fill_valid, 1);
      chk("t2_fill_a", fill_addr, addrs[i]);
      chk("t2_fill_d", fill_data, line_of(addrs[i]));
    end
    give_resp(32'h500);
    tick();
    dfp_resp = 1'b0;
    chk("t2_fill_500", fill_addr, 32'h500);
    chk("t2_outst_0", outstanding, 0);

    // merged misses to one line
    give_miss(32'h2004);
    chk("t3_ready0", miss_ready, 1);
    tick();
    chk("t3_read", dfp_read, 1);
    chk("t3_addr", dfp_addr, 32'h2000);
    give_miss(32'h2010);
    chk("t3_ready1", miss_ready, 1);
    tick();
    chk("t3_no_read1", dfp_read, 0);
    give_miss(32'h201C);
    chk("t3_ready2", miss_ready, 1);
    tick();
    chk("t3_no_read2", dfp_read, 0);
    chk("t3_outst", outstanding, 1);
    give_resp(32'h2000);
    give_miss(32'h2008);
    chk("t3_merge_on_resp", miss_ready, 1);
    tick();
    miss_valid = 1'b0;
    dfp_resp   = 1'b0;
    chk("t3_fill", fill_valid, 1);
    chk("t3_fill_addr", fill_addr, 32'h2000);
    chk("t3_no_realloc", outstanding, 0);
    chk("t3_no_read3", dfp_read, 0);
    tick();
    chk("t3_one_fill", fill_valid, 0);

    // flush orphans an issued read
    give_miss(32'h3000);
    tick();
    chk("t4_read", dfp_addr, 32'h3000);
    flush = 1'b1;
    give_miss(32'h3040);
    chk("t4_flush_ready", miss_ready, 0);
    tick();
    flush      = 1'b0;
    miss_valid = 1'b0;
    chk("t4_no_read", dfp_read, 0);
    chk("t4_orphan_outst", outstanding, 1);
    give_resp(32'h3000);
    tick();
    dfp_resp = 1'b0;
    chk("t4_no_fill", fill_valid, 0);
    chk("t4_no_unmatched", unmatched_resp, 0);
    chk("t4_outst_0", outstanding, 0);
    give_miss(32'h3000);
    chk("t4_realloc_ready", miss_ready, 1);
    tick();
    miss_valid = 1'b0;
    chk("t4_reissue", dfp_read, 1);
    chk("t4_reissue_addr", dfp_addr, 32'h3000);
    give_resp(32'h3000);
    tick();
    dfp_resp = 1'b0;
    chk("t4_fill", fill_valid, 1);

    // unmatched response
    give_resp(32'h7000);
    tick();
    dfp_resp = 1'b0;
    chk("t5_unmatched", unmatched_resp, 1);
    chk("t5_no_fill", fill_valid, 0);
    tick();
    chk("t5_unmatched_pulse", unmatched_resp, 0);

    // reset mid-operation
    give_miss(32'h5000);
    tick();
    miss_valid = 1'b0;
    chk("t6_read", dfp_read, 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("t6_outst_cleared", outstanding, 0);
    give_resp(32'h5000);
    tick();
    dfp_resp = 1'b0;
    chk("t6_unmatched", unmatched_resp, 1);
    chk("t6_no_fill", fill_valid, 0);

    // next-line prefetch (or demand-only)
    give_miss(32'h4000);
    chk("t7_ready", miss_ready, 1);
    tick();
    miss_valid = 1'b0;
    chk("t7_read0", dfp_read, 1);
    chk("t7_addr0", dfp_addr, 32'h4000);
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
    chk("t7_outst2", outstanding, 2);
    tick();
    chk("t7_read1", dfp_read, 1);
    chk("t7_addr1", dfp_addr, 32'h4020);
    give_resp(32'h4020);
    tick();
    chk("t7_pf_fill", fill_addr, 32'h4020);
`else
    chk("t7_outst1", outstanding, 1);
    tick();
    chk("t7_no_pf", dfp_read, 0);
`endif
    give_resp(32'h4000);
    tick();
    dfp_resp = 1'b0;
    chk("t7_fill", fill_addr, 32'h4000);
    chk("t7_outst0", outstanding, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
